hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 34 +++
 rtl/hazard_unit_reg_addr_match.sv | 14 +
 rtl/hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_hazard_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg -- shared types and constants for the hazard unit.
//   REG_W        : register-number width
//   FWD_*        : X-stage operand select encodings
//   md_state_e   : multdiv tracker states
//   stage_t      : M/W shadow stage contents
//   xstage_t     : X shadow stage contents (adds source registers)
package hazard_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } stage_t;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
    logic             is_load;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } xstage_t;

endpackage

// File: rtl/hazard_unit_reg_addr_match.sv
// reg_addr_match -- register-number compare where r0 never matches.
//   a_i, b_i : register numbers
//   match_o  : 1 when a_i == b_i and both are nonzero
module reg_addr_match
  import hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] a_i,
  input  logic [REG_W-1:0] b_i,
  output logic             match_o
);

  assign match_o = (a_i == b_i) && (a_i != '0);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit -- load-use / multdiv stall and X-stage forwarding control.
// Optional feature macro: HAZARD_MULTDIV_EN (multdiv busy tracker + stall).
//   clk_i, rst_ni           : clock, async active-low reset
//   d_valid_i               : decode holds a real instruction
//   d_rs1_i, d_rs2_i, d_rd_i: decode source/destination registers
//   d_is_load_i, d_is_md_i  : decode instruction class
//   flush_i                 : taken branch in X, squash the incoming X
//   stall_o                 : hold PC and F/D, bubble into X
//   fwd_a_o, fwd_b_o        : X operand select (regfile / M / W)
//   md_busy_o, md_done_o    : multdiv in flight / result-written pulse
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             d_valid_i,
  input  logic [REG_W-1:0] d_rs1_i,
  input  logic [REG_W-1:0] d_rs2_i,
  input  logic [REG_W-1:0] d_rd_i,
  input  logic             d_is_load_i,
  input  logic             d_is_md_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             md_busy_o,
  output logic             md_done_o
);

  xstage_t x_q, x_d;
  stage_t  m_q, w_q;

  logic [1:0][REG_W-1:0] d_rs, x_rs;
  logic [1:0]            lu_hit, m_hit, w_hit;
  logic [1:0][1:0]       fwd;
  logic                  lu_stall, md_stall, advance, x_enter;

  assign d_rs = {d_rs2_i, d_rs1_i};
  assign x_rs = {x_q.rs2, x_q.rs1};

  // Per-operand compares: load-use against X.rd, forwarding against M/W.rd.
  for (genvar i = 0; i < 2; i++) begin : g_op
    reg_addr_match u_lu (.a_i(d_rs[i]), .b_i(x_q.rd), .match_o(lu_hit[i]));
    reg_addr_match u_m  (.a_i(x_rs[i]), .b_i(m_q.rd), .match_o(m_hit[i]));
    reg_addr_match u_w  (.a_i(x_rs[i]), .b_i(w_q.rd), .match_o(w_hit[i]));

    // M is the younger producer, so it wins over W.
    assign fwd[i] = (x_q.vld && m_q.vld && m_hit[i]) ? FWD_MEM :
                    (w_q.vld && w_hit[i])             ? FWD_WB  : FWD_REGFILE;
  end

  assign fwd_a_o = fwd[0];
  assign fwd_b_o = fwd[1];

  assign lu_stall = d_valid_i && x_q.vld && x_q.is_load && (|lu_hit);
  // A flush squashes the dependent anyway, so it overrides every stall.
  assign stall_o  = !flush_i && (lu_stall || md_stall);
  assign advance  = d_valid_i && !stall_o && !flush_i;

`ifdef HAZARD_MULTDIV_EN
  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  md_state_e             st_q, st_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_W-1:0]      md_rd_q, md_rd_d;
  logic [2:0][REG_W-1:0] d_src;
  logic [2:0]            md_hit;
  logic                  md_done;

  assign d_src = {d_rd_i, d_rs2_i, d_rs1_i};

  // Decode reads or overwrites the pending result register.
  for (genvar j = 0; j < 3; j++) begin : g_md
    reg_addr_match u_md (.a_i(d_src[j]), .b_i(md_rd_q), .match_o(md_hit[j]));
  end

  assign md_stall  = (st_q == MD_BUSY) && d_valid_i && ((|md_hit) || d_is_md_i);
  // A multdiv lives only in the tracker; it never occupies X.
  assign x_enter   = advance && !d_is_md_i;
  assign md_busy_o = (st_q == MD_BUSY);
  assign md_done_o = md_done;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    md_done = 1'b0;
    unique case (st_q)
      MD_IDLE: begin
        if (advance && d_is_md_i) begin
          st_d    = MD_BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 1);
          md_rd_d = d_rd_i;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          md_done = 1'b1;
          st_d    = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: st_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= MD_IDLE;
      cnt_q   <= '0;
      md_rd_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
    end
  end
`else
  // Multdiv is treated as an ordinary ALU op in this build.
  localparam int unused_md_latency = MD_LATENCY;
  logic unused_md;

  assign unused_md = d_is_md_i;
  assign md_stall  = 1'b0;
  assign x_enter   = advance;
  assign md_busy_o = 1'b0;
  assign md_done_o = 1'b0;
`endif

  // Bubbles carry zeroed fields so stale register numbers never compare.
  always_comb begin
    x_d = '0;
    if (x_enter) begin
      x_d.vld     = 1'b1;
      x_d.rd      = d_rd_i;
      x_d.is_load = d_is_load_i;
      x_d.rs1     = d_rs1_i;
      x_d.rs2     = d_rs2_i;
    end
  end

  logic unused_w_load;
  assign unused_w_load = w_q.is_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      x_q <= x_d;
      m_q <= '{vld: x_q.vld, rd: x_q.rd, is_load: x_q.is_load};
      w_q <= m_q;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit -- directed + random check of hazard_unit against a
// history-of-issued-instructions reference model.
module tb_hazard_unit;

  localparam int LAT = 4;
`ifdef HAZARD_MULTDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic       d_is_load = 1'b0, d_is_md = 1'b0, flush = 1'b0;
  logic       stall, md_busy, md_done;
  logic [1:0] fwd_a, fwd_b;

  hazard_unit #(.MD_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .d_valid_i(d_valid),
    .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .d_rd_i(d_rd),
    .d_is_load_i(d_is_load), .d_is_md_i(d_is_md), .flush_i(flush),
    .stall_o(stall), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .md_busy_o(md_busy), .md_done_o(md_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit ld;
  } op_t;

  op_t hist[$];   // [0] = instruction now in X, [1] = in M, [2] = in W
  int  md_left;   // remaining busy cycles of the multdiv in flight
  int  md_rd;
  int  nchk = 0, nerr = 0;

  logic       obs_stall, obs_busy, obs_done;
  logic [1:0] obs_fa, obs_fb;

  function automatic bit rmatch(int a, int b);
    return (a != 0) && (a == b);
  endfunction

  function automatic int fsel(op_t x, op_t m, op_t w, int rs);
    if (x.v && m.v && rmatch(rs, m.rd)) return 1;
    if (x.v && w.v && rmatch(rs, w.rd)) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    op_t b;
    b = '{v: 1'b0, rd: 0, rs1: 0, rs2: 0, ld: 1'b0};
    hist.delete();
    repeat (3) hist.push_back(b);
    md_left = 0;
    md_rd   = 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive decode, check outputs mid-cycle, advance model.
  task automatic cyc(input bit dv, input int rs1, input int rs2, input int rd,
                     input bit ld, input bit md, input bit fl, input string tag);
    op_t x, m, w, e;
    bit  lu, mds, st, ent;
    d_valid = dv; d_rs1 = rs1[4:0]; d_rs2 = rs2[4:0]; d_rd = rd[4:0];
    d_is_load = ld; d_is_md = md; flush = fl;
    @(negedge clk);
    x = hist[0]; m = hist[1]; w = hist[2];
    lu  = dv && x.v && x.ld && (rmatch(rs1, x.rd) || rmatch(rs2, x.rd));
    mds = MD_EN && (md_left > 0) && dv &&
          (rmatch(rs1, md_rd) || rmatch(rs2, md_rd) || rmatch(rd, md_rd) || md);
    st  = !fl && (lu || mds);
    obs_stall = stall; obs_fa = fwd_a; obs_fb = fwd_b;
    obs_busy = md_busy; obs_done = md_done;
    chk({tag, ".stall"}, obs_stall, st);
    chk({tag, ".fwd_a"}, obs_fa, fsel(x, m, w, x.rs1));
    chk({tag, ".fwd_b"}, obs_fb, fsel(x, m, w, x.rs2));
    chk({tag, ".busy"},  obs_busy, md_left > 0);
    chk({tag, ".done"},  obs_done, md_left == 1);
    if (md_left > 0) md_left--;
    else if (MD_EN && dv && md && !st && !fl) begin
      md_left = LAT;
      md_rd   = rd;
    end
    ent = dv && !st && !fl && !(MD_EN && md);
    e = ent ? '{v: 1'b1, rd: rd, rs1: rs1, rs2: rs2, ld: ld}
            : '{v: 1'b0, rd: 0, rs1: 0, rs2: 0, ld: 1'b0};
    hist.push_front(e);
    void'(hist.pop_back());
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".stall"}, stall, 1'b0);
    chk({tag, ".fwd_a"}, fwd_a, 2'b00);
    chk({tag, ".fwd_b"}, fwd_b, 2'b00);
    chk({tag, ".busy"},  md_busy, 1'b0);
    chk({tag, ".done"},  md_done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    chk_reset_outs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use: one stall cycle, then the dependent issues. By the time it
    // reaches X the load has moved on to W, so W is the forwarding source.
    cyc(1, 0, 0, 5, 1, 0, 0, "ld5");
    cyc(1, 5, 0, 6, 0, 0, 0, "use5a");
    chk("lu_stall_on", obs_stall, 1'b1);
    cyc(1, 5, 0, 6, 0, 0, 0, "use5b");
    chk("lu_stall_off", obs_stall, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, "use5c");
    chk("lu_fwd_a", obs_fa, 2'b10);

    // rs2 forwarding: M beats W, then W alone.
    cyc(1, 0, 0, 3, 0, 0, 0, "p3a");
    cyc(1, 0, 0, 3, 0, 0, 0, "p3b");
    cyc(1, 0, 3, 1, 0, 0, 0, "c3");
    cyc(0, 0, 0, 0, 0, 0, 0, "fb_m");
    chk("fwd_b_mem", obs_fb, 2'b01);
    cyc(1, 0, 0, 3, 0, 0, 0, "q3a");
    cyc(0, 0, 0, 0, 0, 0, 0, "q3gap");
    cyc(1, 0, 3, 1, 0, 0, 0, "d3");
    cyc(0, 0, 0, 0, 0, 0, 0, "fb_w");
    chk("fwd_b_wb", obs_fb, 2'b10);

    // r0 never creates a dependency.
    cyc(1, 0, 0, 0, 1, 0, 0, "ld0");
    cyc(1, 0, 0, 2, 0, 0, 0, "use0");
    chk("r0_stall", obs_stall, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, "fwd0");
    chk("r0_fwd_a", obs_fa, 2'b00);

    // Flush beats load-use and squashes the incoming X.
    cyc(1, 0, 0, 5, 1, 0, 0, "ld5f");
    cyc(1, 5, 0, 6, 0, 0, 1, "luflush");
    chk("flush_stall", obs_stall, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, "squashed");
    chk("flush_xbubble", obs_fa, 2'b00);

`ifdef HAZARD_MULTDIV_EN
    // Multdiv to r7, dependent held through the md_done cycle.
    cyc(1, 0, 0, 7, 0, 1, 0, "mul7");
    chk("md_issue_stall", obs_stall, 1'b0);
    for (int i = 1; i <= LAT; i++) begin
      cyc(1, 7, 0, 8, 0, 0, 0, "mdwait");
      chk("md_wait_stall", obs_stall, 1'b1);
      chk("md_wait_done", obs_done, (i == LAT));
    end
    cyc(1, 7, 0, 8, 0, 0, 0, "mdrel");
    chk("md_rel_stall", obs_stall, 1'b0);
    chk("md_rel_busy", obs_busy, 1'b0);

    // Reset in the second busy cycle kills the multdiv without md_done.
    cyc(1, 0, 0, 7, 0, 1, 0, "mul7r");
    cyc(1, 7, 0, 8, 0, 0, 0, "busy1");
    d_valid = 1'b1; d_rs1 = 5'd7; d_rs2 = '0; d_rd = 5'd8;
    d_is_load = 1'b0; d_is_md = 1'b0; flush = 1'b0;
    #2;
    chk("busy2_stall", stall, 1'b1);
    chk("busy2_busy", md_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_busy");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < LAT + 2; i++) cyc(1, 7, 0, 8, 0, 0, 0, "postrst");
`else
    // Multdiv flag ignored: behaves as an ALU op that feeds forwarding.
    cyc(1, 0, 0, 3, 0, 1, 0, "md_alu");
    chk("md_alu_busy", obs_busy, 1'b0);
    cyc(1, 3, 0, 4, 0, 0, 0, "md_use");
    chk("md_use_stall", obs_stall, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, "md_fwd");
    chk("md_as_alu_fwd", obs_fa, 2'b01);

    // Async reset mid-cycle with forwarding active.
    cyc(1, 0, 0, 2, 0, 0, 0, "pr2");
    cyc(1, 2, 2, 9, 0, 0, 0, "cr2");
    #2;
    chk("pre_rst_fwd", fwd_a, 2'b01);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
`endif

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 9) == 0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
